alu_arbiter: RTL

Shares one `alu` instance between two requesters using round-robin arbitration. Requests use a valid/ready handshake. Operands are registered, the result is captured one cycle later, and it is returned on a single response channel tagged with the source index. The block sits between the register-file/operand-select logic of two client units and the shared `alu` datapath.

---
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with internal alu)
// Purpose  : Round-robin sharing of one registered alu between two requesters;
//            optional per-requester grant counters under ALU_ARBITER_STATS_EN.
// Revision : 1.0
// ============================================================================

module alu #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 3
) (
    input  logic [1:0]       operation_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [SHIFT-1:0] shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);
    // 00 add, 01 subtract, 10 bitwise and, 11 shift x left by shamt
    always_comb begin
        result_o = '0;
        case (operation_i)
            2'b00:   result_o = x_i + y_i;
            2'b01:   result_o = x_i - y_i;
            2'b10:   result_o = x_i & y_i;
            default: result_o = x_i << shamt_i;
        endcase
    end

    assign zero_o = (result_o == '0);
endmodule

module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_operation,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [SHIFT-1:0] req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_operation,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [SHIFT-1:0] req1_shamt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             prio_q;
    logic             src_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [SHIFT-1:0] shamt_q;
    logic             rsp_valid_q;
    logic             rsp_src_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;

    logic             grant;
    logic             handshake;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = prio_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is withheld during reset and whenever a command is in flight
    assign req0_ready = !rst && (state_q == S_IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state_q == S_IDLE) && req1_valid && grant;
    assign handshake  = req0_ready || req1_ready;

    alu #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_alu (
        .operation_i (op_q),
        .x_i         (x_q),
        .y_i         (y_q),
        .shamt_i     (shamt_q),
        .result_o    (alu_result),
        .zero_o      (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            src_q        <= 1'b0;
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            shamt_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_src_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        op_q    <= grant ? req1_operation : req0_operation;
                        x_q     <= grant ? req1_x         : req0_x;
                        y_q     <= grant ? req1_y         : req0_y;
                        shamt_q <= grant ? req1_shamt     : req0_shamt;
                        src_q   <= grant;
                        prio_q  <= ~grant;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero;
                    rsp_src_q    <= src_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_src    = rsp_src_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (req1_ready && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif
endmodule

`default_nettype wire
